rob_mc: RTL and testbench

Parametrised reorder buffer: the next generation of the single-commit ROB.
- Depth, commit width and full-slack are parameters.
- Commits up to COMMIT_W in-order entries per cycle.
- Exposes an occupancy count.
- Optional same-cycle writeback forwarding on the operand query ports.
- Sits between decoder (allocation), RS/LSB (writeback), register file (commit) and predictor/ifetch (branch resolve, flush).

---
 rtl/rob_mc_pkg.sv | 22 ++
 rtl/rob_mc_commit_sel.sv | 39 +++
 rtl/rob_mc.sv | 174 +++++++++++++++++
 tb/tb_rob_mc.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_mc_pkg.sv
// Shared encodings and entry layout for the multi-commit reorder buffer.
package rob_mc_pkg;
  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ROB_OP_REG = 2'd0,
    ROB_OP_BR  = 2'd1,
    ROB_OP_MEM = 2'd2
  } rob_op_e;

  typedef struct packed {
    logic                 valid;
    logic                 ready;
    rob_op_e              op;
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_W-1:0]    val;
    logic                 pred_jump;
    logic [DATA_W-1:0]    pc;
    logic [DATA_W-1:0]    alt_pc;
  } rob_entry_t;
endpackage

// File: rtl/rob_mc_commit_sel.sv
// Combinational commit-lane selection: which head entries retire this cycle.
module rob_commit_sel #(
  parameter int COMMIT_W = 2,
  parameter int IDX_W    = 4
) (
  input  logic [IDX_W-1:0]                   head,
  input  logic [COMMIT_W-1:0]                lane_valid,
  input  logic [COMMIT_W-1:0]                lane_ready,
  input  logic [COMMIT_W-1:0]                lane_br,
  input  logic                               head_mem,
  input  logic                               head_taken,
  input  logic                               head_pred,
  output logic [COMMIT_W-1:0]                cm_vec,
  output logic [COMMIT_W-1:0][IDX_W-1:0]     lane_idx,
  output logic [1:0]                         n_commit,
  output logic                               mispredict
);
  logic c0;

  // Memory ops retire once valid; their completion is tracked by the LSB.
  assign c0        = lane_valid[0] & (lane_ready[0] | head_mem);
  assign cm_vec[0] = c0;

  for (genvar l = 0; l < COMMIT_W; l++) begin : g_idx
    assign lane_idx[l] = head + IDX_W'(l);
  end

  // A branch always retires alone so a flush never races a second lane.
  if (COMMIT_W > 1) begin : g_lane1
    assign cm_vec[1] = c0 & lane_valid[1] & lane_ready[1] & ~lane_br[0] & ~lane_br[1];
  end

  always_comb begin
    n_commit = '0;
    for (int l = 0; l < COMMIT_W; l++) n_commit = n_commit + 2'(cm_vec[l]);
  end

  assign mispredict = c0 & lane_br[0] & (head_taken != head_pred);
endmodule

// File: rtl/rob_mc.sv
// Parametrised multi-commit reorder buffer with occupancy count.
// Optional ROB_WB_FWD_EN: operand queries also see same-cycle writebacks.
module rob_mc
  import rob_mc_pkg::*;
#(
  parameter int ROB_SIZE   = 16,
  parameter int COMMIT_W   = 2,
  parameter int FULL_SLACK = 3,
  parameter int IDX_W      = $clog2(ROB_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      alloc_en,
  input  logic [1:0]                alloc_op,
  input  logic [4:0]                alloc_dest,
  input  logic                      alloc_ready,
  input  logic [31:0]               alloc_val,
  input  logic                      alloc_pred_jump,
  input  logic [31:0]               alloc_pc,
  input  logic [31:0]               alloc_alt_pc,
  output logic [IDX_W-1:0]          alloc_idx,
  output logic                      full,
  output logic                      empty,
  output logic [IDX_W:0]            count,
  input  logic                      rs_wb_en,
  input  logic [IDX_W-1:0]          rs_wb_idx,
  input  logic [31:0]               rs_wb_val,
  input  logic                      lsb_wb_en,
  input  logic [IDX_W-1:0]          lsb_wb_idx,
  input  logic [31:0]               lsb_wb_val,
  input  logic [IDX_W-1:0]          rs1_q_idx,
  input  logic [IDX_W-1:0]          rs2_q_idx,
  output logic                      rs1_q_ready,
  output logic                      rs2_q_ready,
  output logic [31:0]               rs1_q_val,
  output logic [31:0]               rs2_q_val,
  output logic [COMMIT_W-1:0]       cm_en,
  output logic [COMMIT_W-1:0]       cm_rf_en,
  output logic [COMMIT_W*IDX_W-1:0] cm_idx,
  output logic [COMMIT_W*5-1:0]     cm_dest,
  output logic [COMMIT_W*32-1:0]    cm_val,
  output logic                      br_en,
  output logic [31:0]               br_pc,
  output logic                      br_taken,
  output logic                      flush,
  output logic [31:0]               flush_pc
);
  rob_entry_t ent [ROB_SIZE];
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   cnt;

  logic [COMMIT_W-1:0]            l_valid, l_ready, l_br, cm_vec;
  logic [COMMIT_W-1:0][IDX_W-1:0] l_idx;
  logic [1:0]                     n_commit;
  logic                           mispredict, alloc_ok, rs_ok, lsb_ok;

  always_comb begin
    for (int l = 0; l < COMMIT_W; l++) begin
      l_valid[l] = ent[l_idx[l]].valid;
      l_ready[l] = ent[l_idx[l]].ready;
      l_br[l]    = ent[l_idx[l]].op == ROB_OP_BR;
    end
  end

  rob_commit_sel #(.COMMIT_W(COMMIT_W), .IDX_W(IDX_W)) u_sel (
    .head       (head),
    .lane_valid (l_valid),
    .lane_ready (l_ready),
    .lane_br    (l_br),
    .head_mem   (ent[head].op == ROB_OP_MEM),
    .head_taken (ent[head].val[0]),
    .head_pred  (ent[head].pred_jump),
    .cm_vec     (cm_vec),
    .lane_idx   (l_idx),
    .n_commit   (n_commit),
    .mispredict (mispredict)
  );

  // The flush cycle and a mispredicting commit both swallow new work.
  assign alloc_ok = rdy_in & ~flush & ~mispredict & alloc_en & (cnt != (IDX_W+1)'(ROB_SIZE));
  assign rs_ok    = rdy_in & ~flush & rs_wb_en  & ent[rs_wb_idx].valid;
  assign lsb_ok   = rdy_in & ~flush & lsb_wb_en & ent[lsb_wb_idx].valid;

  assign alloc_idx = tail;
  assign count     = cnt;
  assign empty     = cnt == '0;
  assign full      = int'(cnt) >= ROB_SIZE - FULL_SLACK;

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      head <= '0; tail <= '0; cnt <= '0;
      for (int i = 0; i < ROB_SIZE; i++) ent[i].valid <= 1'b0;
      cm_en <= '0; cm_rf_en <= '0; cm_idx <= '0; cm_dest <= '0; cm_val <= '0;
      br_en <= 1'b0; br_pc <= '0; br_taken <= 1'b0;
      flush <= 1'b0; flush_pc <= '0;
    end else if (rdy_in) begin
      cm_en <= cm_vec;
      for (int l = 0; l < COMMIT_W; l++) begin
        cm_rf_en[l]             <= cm_vec[l] & (ent[l_idx[l]].op == ROB_OP_REG);
        cm_idx[l*IDX_W +: IDX_W] <= cm_vec[l] ? l_idx[l] : '0;
        cm_dest[l*5 +: 5]       <= cm_vec[l] ? ent[l_idx[l]].dest : '0;
        cm_val[l*32 +: 32]      <= cm_vec[l] ? ent[l_idx[l]].val : '0;
      end
      br_en    <= cm_vec[0] & l_br[0];
      br_pc    <= (cm_vec[0] & l_br[0]) ? ent[head].pc : '0;
      br_taken <= cm_vec[0] & l_br[0] & ent[head].val[0];
      flush    <= mispredict;
      flush_pc <= mispredict ? ent[head].alt_pc : '0;
      if (mispredict) begin
        head <= '0; tail <= '0; cnt <= '0;
        for (int i = 0; i < ROB_SIZE; i++) ent[i].valid <= 1'b0;
      end else begin
        // Later assignments win: LSB over RS, allocation over both.
        if (rs_ok) begin
          ent[rs_wb_idx].ready <= 1'b1;
          ent[rs_wb_idx].val   <= rs_wb_val;
        end
        if (lsb_ok) begin
          ent[lsb_wb_idx].ready <= 1'b1;
          ent[lsb_wb_idx].val   <= lsb_wb_val;
        end
        for (int l = 0; l < COMMIT_W; l++)
          if (cm_vec[l]) ent[l_idx[l]].valid <= 1'b0;
        if (alloc_ok) begin
          ent[tail].valid     <= 1'b1;
          ent[tail].ready     <= alloc_ready;
          ent[tail].op        <= rob_op_e'(alloc_op);
          ent[tail].dest      <= alloc_dest;
          ent[tail].val       <= alloc_val;
          ent[tail].pred_jump <= alloc_pred_jump;
          ent[tail].pc        <= alloc_pc;
          ent[tail].alt_pc    <= alloc_alt_pc;
        end
        head <= head + IDX_W'(n_commit);
        tail <= tail + IDX_W'(alloc_ok);
        cnt  <= cnt + (IDX_W+1)'(alloc_ok) - (IDX_W+1)'(n_commit);
      end
    end
  end

  logic [IDX_W-1:0] q_idx [2];
  logic             q_rdy [2];
  logic [31:0]      q_val [2];

  assign q_idx[0] = rs1_q_idx;
  assign q_idx[1] = rs2_q_idx;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_rdy[p] = ent[q_idx[p]].valid & ent[q_idx[p]].ready;
      q_val[p] = ent[q_idx[p]].val;
`ifdef ROB_WB_FWD_EN
      if (rs_ok && rs_wb_idx == q_idx[p]) begin
        q_rdy[p] = 1'b1;
        q_val[p] = rs_wb_val;
      end
      if (lsb_ok && lsb_wb_idx == q_idx[p]) begin
        q_rdy[p] = 1'b1;
        q_val[p] = lsb_wb_val;
      end
`endif
      if (alloc_ok && alloc_ready && tail == q_idx[p]) begin
        q_rdy[p] = 1'b1;
        q_val[p] = alloc_val;
      end
    end
  end

  assign rs1_q_ready = q_rdy[0];
  assign rs1_q_val   = q_val[0];
  assign rs2_q_ready = q_rdy[1];
  assign rs2_q_val   = q_val[1];
endmodule

// File: tb/tb_rob_mc.sv
// Directed bench for rob_mc: a cycle table plus hand sequences for full, query and wrap.
module tb_rob_mc;
  localparam int RSZ = 16, CW = 2, FS = 3, IW = 4;
  localparam logic [1:0] OP_REG = 2'd0, OP_BR = 2'd1, OP_MEM = 2'd2;

  logic clk = 1'b0, rst_n_in, rdy_in;
  logic alloc_en, alloc_ready, alloc_pred_jump;
  logic [1:0] alloc_op;
  logic [4:0] alloc_dest;
  logic [31:0] alloc_val, alloc_pc, alloc_alt_pc;
  logic [IW-1:0] alloc_idx;
  logic full, empty;
  logic [IW:0] count;
  logic rs_wb_en, lsb_wb_en;
  logic [IW-1:0] rs_wb_idx, lsb_wb_idx, rs1_q_idx, rs2_q_idx;
  logic [31:0] rs_wb_val, lsb_wb_val, rs1_q_val, rs2_q_val;
  logic rs1_q_ready, rs2_q_ready;
  logic [CW-1:0] cm_en, cm_rf_en;
  logic [CW*IW-1:0] cm_idx;
  logic [CW*5-1:0] cm_dest;
  logic [CW*32-1:0] cm_val;
  logic br_en, br_taken, flush;
  logic [31:0] br_pc, flush_pc;

  rob_mc #(.ROB_SIZE(RSZ), .COMMIT_W(CW), .FULL_SLACK(FS)) dut (
    .clk(clk), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .alloc_en(alloc_en), .alloc_op(alloc_op), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_val(alloc_val), .alloc_pred_jump(alloc_pred_jump),
    .alloc_pc(alloc_pc), .alloc_alt_pc(alloc_alt_pc), .alloc_idx(alloc_idx),
    .full(full), .empty(empty), .count(count),
    .rs_wb_en(rs_wb_en), .rs_wb_idx(rs_wb_idx), .rs_wb_val(rs_wb_val),
    .lsb_wb_en(lsb_wb_en), .lsb_wb_idx(lsb_wb_idx), .lsb_wb_val(lsb_wb_val),
    .rs1_q_idx(rs1_q_idx), .rs2_q_idx(rs2_q_idx),
    .rs1_q_ready(rs1_q_ready), .rs2_q_ready(rs2_q_ready),
    .rs1_q_val(rs1_q_val), .rs2_q_val(rs2_q_val),
    .cm_en(cm_en), .cm_rf_en(cm_rf_en), .cm_idx(cm_idx), .cm_dest(cm_dest), .cm_val(cm_val),
    .br_en(br_en), .br_pc(br_pc), .br_taken(br_taken), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic a_en; logic [1:0] a_op; logic a_rdy; logic [31:0] a_val; logic a_pj; logic [31:0] a_pc;
    logic rs_en; logic [3:0] rs_idx; logic [31:0] rs_val;
    logic lsb_en; logic [3:0] lsb_idx; logic [31:0] lsb_val;
    logic [1:0] e_cm, e_rf; logic [3:0] e_i0; logic [31:0] e_v0, e_v1;
    logic [4:0] e_cnt; logic [3:0] e_tail;
    logic e_br, e_tk; logic [31:0] e_bpc; logic e_fl; logic [31:0] e_fpc;
  } vec_t;

  function automatic vec_t vi();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t va(input logic [1:0] op, input logic rdy, input logic [31:0] val,
                              input logic pj, input logic [31:0] pc);
    vec_t v = vi();
    v.a_en = 1'b1; v.a_op = op; v.a_rdy = rdy; v.a_val = val; v.a_pj = pj; v.a_pc = pc;
    return v;
  endfunction

  function automatic vec_t vw(input logic re, input logic [3:0] ri, input logic [31:0] rv,
                              input logic le, input logic [3:0] li, input logic [31:0] lv);
    vec_t v = vi();
    v.rs_en = re; v.rs_idx = ri; v.rs_val = rv; v.lsb_en = le; v.lsb_idx = li; v.lsb_val = lv;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vin, input logic [1:0] cm, input logic [1:0] rf,
                              input logic [3:0] i0, input logic [31:0] v0, input logic [31:0] v1,
                              input logic [4:0] cnt, input logic [3:0] tl,
                              input logic br, input logic tk, input logic [31:0] bpc,
                              input logic fl, input logic [31:0] fpc);
    vec_t v = vin;
    v.e_cm = cm; v.e_rf = rf; v.e_i0 = i0; v.e_v0 = v0; v.e_v1 = v1; v.e_cnt = cnt;
    v.e_tail = tl; v.e_br = br; v.e_tk = tk; v.e_bpc = bpc; v.e_fl = fl; v.e_fpc = fpc;
    return v;
  endfunction

  task automatic clear_in();
    alloc_en = 0; alloc_op = 0; alloc_dest = 0; alloc_ready = 0; alloc_val = 0;
    alloc_pred_jump = 0; alloc_pc = 0; alloc_alt_pc = 0;
    rs_wb_en = 0; rs_wb_idx = 0; rs_wb_val = 0; lsb_wb_en = 0; lsb_wb_idx = 0; lsb_wb_val = 0;
  endtask

  task automatic alloc1(input logic [1:0] op, input logic rdy, input logic [31:0] val);
    clear_in();
    alloc_en = 1; alloc_op = op; alloc_ready = rdy; alloc_val = val;
    tick();
    clear_in();
  endtask

  vec_t tbl [36];
  logic [3:0] i1;
  logic fwd;
  int exp_n;

  initial begin
`ifdef ROB_WB_FWD_EN
    fwd = 1'b1;
`else
    fwd = 1'b0;
`endif
    // cm, rf, i0, v0, v1, cnt, tail, br, tk, bpc, fl, fpc
    tbl[0]  = ex(va(OP_REG,0,0,0,0),          0,0,0,0,0, 1,1,  0,0,0,0,0);
    tbl[1]  = ex(va(OP_REG,0,0,0,0),          0,0,0,0,0, 2,2,  0,0,0,0,0);
    tbl[2]  = ex(va(OP_REG,0,0,0,0),          0,0,0,0,0, 3,3,  0,0,0,0,0);
    tbl[3]  = ex(vw(1,0,'h11,1,1,'h22),       0,0,0,0,0, 3,3,  0,0,0,0,0);
    tbl[4]  = ex(vw(1,2,'h33,0,0,0),          3,3,0,'h11,'h22, 1,3, 0,0,0,0,0);
    tbl[5]  = ex(vi(),                        1,1,2,'h33,0, 0,3, 0,0,0,0,0);
    tbl[6]  = ex(vi(),                        0,0,0,0,0, 0,3,  0,0,0,0,0);
    tbl[7]  = ex(va(OP_REG,1,'h44,0,0),       0,0,0,0,0, 1,4,  0,0,0,0,0);
    tbl[8]  = ex(va(OP_REG,1,'h55,0,0),       1,1,3,'h44,0, 1,5, 0,0,0,0,0);
    tbl[9]  = ex(vi(),                        1,1,4,'h55,0, 0,5, 0,0,0,0,0);
    tbl[10] = ex(va(OP_REG,0,0,0,0),          0,0,0,0,0, 1,6,  0,0,0,0,0);
    tbl[11] = ex(vw(1,5,'hAAAA,1,5,'hBBBB),   0,0,0,0,0, 1,6,  0,0,0,0,0);
    tbl[12] = ex(vi(),                        1,1,5,'hBBBB,0, 0,6, 0,0,0,0,0);
    tbl[13] = ex(vw(1,6,'h99,0,0,0),          0,0,0,0,0, 0,6,  0,0,0,0,0);
    tbl[14] = ex(va(OP_REG,0,0,0,0),          0,0,0,0,0, 1,7,  0,0,0,0,0);
    tbl[15] = ex(vi(),                        0,0,0,0,0, 1,7,  0,0,0,0,0);
    tbl[16] = ex(vw(1,6,'h66,0,0,0),          0,0,0,0,0, 1,7,  0,0,0,0,0);
    tbl[17] = ex(vi(),                        1,1,6,'h66,0, 0,7, 0,0,0,0,0);
    tbl[18] = ex(va(OP_MEM,0,0,0,0),          0,0,0,0,0, 1,8,  0,0,0,0,0);
    tbl[19] = ex(vi(),                        1,0,7,0,0, 0,8,  0,0,0,0,0);
    tbl[20] = ex(va(OP_BR,1,1,1,'h1020),      0,0,0,0,0, 1,9,  0,0,0,0,0);
    tbl[21] = ex(va(OP_REG,1,'h88,0,0),       1,0,8,1,0, 1,10, 1,1,'h1020,0,0);
    tbl[22] = ex(vi(),                        1,1,9,'h88,0, 0,10, 0,0,0,0,0);
    tbl[23] = ex(va(OP_REG,0,0,0,0),          0,0,0,0,0, 1,11, 0,0,0,0,0);
    tbl[24] = ex(va(OP_BR,0,0,0,'h102C),      0,0,0,0,0, 2,12, 0,0,0,0,0);
    tbl[25] = ex(vw(1,10,'hA0,1,11,0),        0,0,0,0,0, 2,12, 0,0,0,0,0);
    tbl[26] = ex(vi(),                        1,1,10,'hA0,0, 1,12, 0,0,0,0,0);
    tbl[27] = ex(vi(),                        1,0,11,0,0, 0,12, 1,0,'h102C,0,0);
    tbl[28] = ex(va(OP_BR,0,0,1,'h1030),      0,0,0,0,0, 1,13, 0,0,0,0,0);
    tbl[29] = ex(va(OP_REG,1,'hD,0,0),        0,0,0,0,0, 2,14, 0,0,0,0,0);
    tbl[30] = ex(va(OP_REG,1,'hE,0,0),        0,0,0,0,0, 3,15, 0,0,0,0,0);
    tbl[31] = ex(va(OP_REG,1,'hF,0,0),        0,0,0,0,0, 4,0,  0,0,0,0,0);
    tbl[31].rs_en = 1; tbl[31].rs_idx = 12; tbl[31].rs_val = 0;
    tbl[32] = ex(vi(),                        1,0,12,0,0, 0,0, 1,0,'h1030,1,'h1130);
    tbl[33] = ex(va(OP_REG,1,5,0,0),          0,0,0,0,0, 0,0,  0,0,0,0,0);
    tbl[34] = ex(va(OP_REG,1,5,0,0),          0,0,0,0,0, 1,1,  0,0,0,0,0);
    tbl[35] = ex(vi(),                        1,1,0,5,0, 0,1,  0,0,0,0,0);

    rst_n_in = 0; rdy_in = 1; rs1_q_idx = 0; rs2_q_idx = 0;
    clear_in();
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_cm_en", 32'(cm_en), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_alloc_idx", 32'(alloc_idx), 0);
    rst_n_in = 1;

    for (int k = 0; k < 36; k++) begin
      alloc_en = tbl[k].a_en; alloc_op = tbl[k].a_op; alloc_ready = tbl[k].a_rdy;
      alloc_val = tbl[k].a_val; alloc_pred_jump = tbl[k].a_pj; alloc_dest = 5'(k);
      alloc_pc = tbl[k].a_pc; alloc_alt_pc = tbl[k].a_pc + 32'h100;
      rs_wb_en = tbl[k].rs_en; rs_wb_idx = tbl[k].rs_idx; rs_wb_val = tbl[k].rs_val;
      lsb_wb_en = tbl[k].lsb_en; lsb_wb_idx = tbl[k].lsb_idx; lsb_wb_val = tbl[k].lsb_val;
      tick();
      chk($sformatf("v%0d_cm_en", k), 32'(cm_en), 32'(tbl[k].e_cm));
      chk($sformatf("v%0d_cm_rf_en", k), 32'(cm_rf_en), 32'(tbl[k].e_rf));
      chk($sformatf("v%0d_count", k), 32'(count), 32'(tbl[k].e_cnt));
      chk($sformatf("v%0d_empty", k), 32'(empty), 32'(tbl[k].e_cnt == 0));
      chk($sformatf("v%0d_alloc_idx", k), 32'(alloc_idx), 32'(tbl[k].e_tail));
      chk($sformatf("v%0d_br_en", k), 32'(br_en), 32'(tbl[k].e_br));
      chk($sformatf("v%0d_flush", k), 32'(flush), 32'(tbl[k].e_fl));
      if (tbl[k].e_cm[0]) begin
        chk($sformatf("v%0d_cm_idx0", k), 32'(cm_idx[3:0]), 32'(tbl[k].e_i0));
        chk($sformatf("v%0d_cm_val0", k), cm_val[31:0], tbl[k].e_v0);
      end
      if (tbl[k].e_cm[1]) begin
        i1 = tbl[k].e_i0 + 4'd1;
        chk($sformatf("v%0d_cm_idx1", k), 32'(cm_idx[7:4]), 32'(i1));
        chk($sformatf("v%0d_cm_val1", k), cm_val[63:32], tbl[k].e_v1);
      end
      if (tbl[k].e_br) begin
        chk($sformatf("v%0d_br_taken", k), 32'(br_taken), 32'(tbl[k].e_tk));
        chk($sformatf("v%0d_br_pc", k), br_pc, tbl[k].e_bpc);
      end
      if (tbl[k].e_fl) chk($sformatf("v%0d_flush_pc", k), flush_pc, tbl[k].e_fpc);
    end
    clear_in();

    // Full threshold: head=tail=1, empty.
    for (int k = 0; k < 13; k++) begin
      alloc1(OP_REG, 0, 0);
      if (k == 11) begin
        chk("full_at12", 32'(full), 0);
        chk("count_at12", 32'(count), 12);
      end
    end
    chk("full_at13", 32'(full), 1);
    chk("count_at13", 32'(count), 13);
    rs_wb_en = 1; rs_wb_idx = 1; rs_wb_val = 32'h31;
    tick();
    clear_in();
    tick();
    chk("full_commit_cm_en", 32'(cm_en), 1);
    chk("full_commit_idx", 32'(cm_idx[3:0]), 1);
    chk("full_after_commit", 32'(full), 0);
    chk("count_after_commit", 32'(count), 12);
    for (int k = 0; k < 4; k++) alloc1(OP_REG, 0, 0);
    chk("count_at_size", 32'(count), 16);
    alloc1(OP_REG, 0, 0);
    chk("overflow_count", 32'(count), 16);
    chk("overflow_alloc_idx", 32'(alloc_idx), 2);

    // Operand query and forwarding.
    rst_n_in = 0; tick(); rst_n_in = 1;
    for (int k = 0; k < 3; k++) alloc1(OP_REG, 0, 0);
    rs1_q_idx = 2; rs2_q_idx = 3;
    #1;
    chk("q_invalid_rdy", 32'(rs2_q_ready), 0);
    rs_wb_en = 1; rs_wb_idx = 2; rs_wb_val = 32'h77;
    alloc_en = 1; alloc_op = OP_REG; alloc_ready = 1; alloc_val = 32'h5A;
    #1;
    chk("q_wb_same_rdy", 32'(rs1_q_ready), 32'(fwd));
    if (fwd) chk("q_wb_same_val", rs1_q_val, 32'h77);
    chk("q_alloc_fwd_rdy", 32'(rs2_q_ready), 1);
    chk("q_alloc_fwd_val", rs2_q_val, 32'h5A);
    tick();
    clear_in();
    #1;
    chk("q_wb_next_rdy", 32'(rs1_q_ready), 1);
    chk("q_wb_next_val", rs1_q_val, 32'h77);
    chk("q_stored_alloc_val", rs2_q_val, 32'h5A);
    rdy_in = 0; alloc_en = 1;
    tick();
    chk("rdy_low_count", 32'(count), 4);
    rdy_in = 1; clear_in();

    // Wrap-around in steady state.
    rst_n_in = 0; tick(); rst_n_in = 1;
    exp_n = 0;
    for (int k = 0; k < 40 && exp_n < 20; k++) begin
      if (k < 20) begin
        alloc_en = 1; alloc_op = OP_REG; alloc_ready = 1; alloc_val = 32'h100 + 32'(k);
      end else clear_in();
      tick();
      for (int l = 0; l < CW; l++) begin
        if (cm_en[l]) begin
          chk($sformatf("wrap_idx%0d", exp_n), 32'(cm_idx[l*IW +: IW]), 32'(exp_n % 16));
          chk($sformatf("wrap_val%0d", exp_n), cm_val[l*32 +: 32], 32'h100 + 32'(exp_n));
          exp_n++;
        end
      end
    end
    clear_in();
    chk("wrap_total", 32'(exp_n), 20);
    tick();
    chk("wrap_count_end", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
